fir_out_stage: RTL and testbench

FIR_OUT_STAGE -- requirements
Module: fir_out_stage

---
 rtl/fir_out_stage.sv | 109 ++++++++++
 tb/tb_fir_out_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_stage.sv
// FIR output stage: round and shift the 34-bit filter result, saturate it to 16 bits,
// and buffer the samples in a first-word-fall-through FIFO with sticky status flags.
module fir_out_stage #(
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_data_tvalid,
  input  logic [33:0]            s_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic [15:0]            m_axis_data_tdata,
  input  logic                   clr,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic signed [34:0] RND      = 35'sd1 <<< (SHIFT - 1);
  localparam logic signed [34:0] MAX_S    = 35'sd32767;
  localparam logic signed [34:0] MIN_S    = -35'sd32768;
  localparam logic [PW:0]        FULL_CNT = (PW + 1)'(DEPTH);

  logic signed [34:0] rnd_sum;
  logic signed [34:0] stg1_r;
  logic               stg1_valid;
  logic [15:0]        sat_data;
  logic               clamp;

  logic [15:0]        mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // Sign-extend to 35 bits so the rounding offset can never overflow.
  always_comb begin
    rnd_sum = ($signed({s_axis_data_tdata[33], s_axis_data_tdata}) + RND) >>> SHIFT;
  end

  always_comb begin
    sat_data = stg1_r[15:0];
    clamp    = 1'b0;
    if (stg1_r > MAX_S) begin
      sat_data = 16'h7fff;
      clamp    = 1'b1;
    end else if (stg1_r < MIN_S) begin
      sat_data = 16'h8000;
      clamp    = 1'b1;
    end
  end

  // A full FIFO still takes the write when the head leaves on the same edge.
  assign full               = (fifo_count == FULL_CNT);
  assign m_axis_data_tvalid = (fifo_count != '0);
  assign m_axis_data_tdata  = mem[rd_ptr];
  assign pop                = m_axis_data_tvalid & m_axis_data_tready;
  assign push               = stg1_valid & (~full | pop);
  assign drop               = stg1_valid & full & ~pop;

  always_ff @(posedge aclk) begin
    if (s_axis_data_tvalid) begin
      stg1_r <= rnd_sum;
    end
    if (push) begin
      mem[wr_ptr] <= sat_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      stg1_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      sat_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      stg1_valid <= s_axis_data_tvalid;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A set event on the same edge as clr takes priority.
      if (stg1_valid && clamp) begin
        sat_flag <= 1'b1;
      end else if (clr) begin
        sat_flag <= 1'b0;
      end
      if (drop) begin
        ovf_flag <= 1'b1;
      end else if (clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed and random checks of fir_out_stage against a cycle-level reference model
// (pipeline register, sample queue, sticky flags).
module tb_fir_out_stage;

  localparam int SHIFT = 15;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_data_tvalid;
  logic [33:0]   s_axis_data_tdata;
  logic          m_axis_data_tvalid;
  logic          m_axis_data_tready;
  logic [15:0]   m_axis_data_tdata;
  logic          clr;
  logic          sat_flag;
  logic          ovf_flag;
  logic [CW-1:0] fifo_count;

  fir_out_stage #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .s_axis_data_tdata  (s_axis_data_tdata),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tready (m_axis_data_tready),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .clr                (clr),
    .sat_flag           (sat_flag),
    .ovf_flag           (ovf_flag),
    .fifo_count         (fifo_count)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clamp to 16 bits.
  function automatic logic [15:0] ref_out(input longint x, output bit sat);
    longint dv, v, q;
    dv = longint'(1) << SHIFT;
    v  = x + dv / 2;
    if (v >= 0) q = v / dv;
    else        q = -((-v + dv - 1) / dv);
    sat = 1'b1;
    if (q > 32767)  return 16'h7fff;
    if (q < -32768) return 16'h8000;
    sat = 1'b0;
    return q[15:0];
  endfunction

  logic [15:0] mq[$];
  bit          m_s1_v   = 1'b0;
  bit          m_s1_sat = 1'b0;
  logic [15:0] m_s1_d   = '0;
  bit          m_sat    = 1'b0;
  bit          m_ovf    = 1'b0;

  // Drive one cycle of inputs, advance the model over the coming edge, then compare.
  task automatic step(input bit v, input longint d, input bit rdy, input bit c, input bit rst);
    bit pop, sat_ev, ovf_ev;
    s_axis_data_tvalid = v;
    s_axis_data_tdata  = d[33:0];
    m_axis_data_tready = rdy;
    clr                = c;
    areset             = rst;
    if (rst) begin
      mq.delete();
      m_s1_v = 1'b0;
      m_sat  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      pop    = (mq.size() > 0) && rdy;
      sat_ev = 1'b0;
      ovf_ev = 1'b0;
      if (pop) void'(mq.pop_front());
      if (m_s1_v) begin
        sat_ev = m_s1_sat;
        if (mq.size() < DEPTH) mq.push_back(m_s1_d);
        else                   ovf_ev = 1'b1;
      end
      if (sat_ev)  m_sat = 1'b1;
      else if (c)  m_sat = 1'b0;
      if (ovf_ev)  m_ovf = 1'b1;
      else if (c)  m_ovf = 1'b0;
      m_s1_v = v;
      if (v) m_s1_d = ref_out(d, m_s1_sat);
    end
    @(posedge aclk);
    @(negedge aclk);
    check("model_tvalid", m_axis_data_tvalid, mq.size() > 0);
    if (mq.size() > 0) check("model_tdata", m_axis_data_tdata, mq[0]);
    check("model_count", fifo_count, mq.size());
    check("model_sat", sat_flag, m_sat);
    check("model_ovf", ovf_flag, m_ovf);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  longint      din[4] = '{16384, -16384, -16385, 49151};
  logic [15:0] dexp[4] = '{16'h0001, 16'h0000, 16'hffff, 16'h0001};

  initial begin
    longint x;
    bit     v, r, c;

    s_axis_data_tvalid = 1'b0;
    s_axis_data_tdata  = '0;
    m_axis_data_tready = 1'b0;
    clr                = 1'b0;
    areset             = 1'b1;

    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 0, 1'b0, 1'b0, 1'b1);
    check("rst_tvalid", m_axis_data_tvalid, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_flags", {sat_flag, ovf_flag}, 2'b00);

    // Rounding: each output shows two edges after its input.
    for (int i = 0; i < 5; i++) begin
      step(i < 4, (i < 4) ? din[i] : 0, 1'b1, 1'b0, 1'b0);
      if (i >= 1) begin
        check("round_tvalid", m_axis_data_tvalid, 1'b1);
        check("round_data", m_axis_data_tdata, dexp[i-1]);
      end
    end
    check("round_sat", sat_flag, 1'b0);
    drain();

    // Saturation, sticky flag, clr, and set-beats-clr.
    step(1'b1, 64'h0_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, -(longint'(1) << 33), 1'b1, 1'b0, 1'b0);
    check("sat_pos_data", m_axis_data_tdata, 16'h7fff);
    check("sat_pos_flag", sat_flag, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("sat_neg_data", m_axis_data_tdata, 16'h8000);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("sat_clr", sat_flag, 1'b0);
    step(1'b1, 64'h0_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("sat_set_wins", sat_flag, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("sat_clr2", sat_flag, 1'b0);
    drain();

    // Overflow: nine beats into a stalled FIFO; the ninth is dropped.
    for (int i = 0; i < 9; i++) step(1'b1, longint'(i + 1) << 15, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", ovf_flag, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_data", m_axis_data_tdata, i + 1);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    check("ovf_drain_empty", m_axis_data_tvalid, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("ovf_clr", ovf_flag, 1'b0);

    // Full FIFO with a pop every edge keeps count at DEPTH and loses nothing.
    for (int i = 0; i < 9; i++) step(1'b1, longint'(i + 1) << 15, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 20; m++) begin
      step(1'b1, longint'(m + 10) << 15, 1'b1, 1'b0, 1'b0);
      check("full_pp_count", fifo_count, 8);
      check("full_pp_ovf", ovf_flag, 1'b0);
      check("full_pp_data", m_axis_data_tdata, m + 2);
    end
    drain();

    // Reset mid-operation: five queued words, one beat in stage 1, one on the reset edge.
    for (int i = 0; i < 6; i++)
      step(1'b1, (i == 0) ? 64'h0_FFFF_FFFF : (longint'(i + 40) << 15), 1'b0, 1'b0, 1'b0);
    check("mid_pre_count", fifo_count, 5);
    check("mid_pre_sat", sat_flag, 1'b1);
    step(1'b1, longint'(77) << 15, 1'b0, 1'b0, 1'b1);
    check("mid_rst_tvalid", m_axis_data_tvalid, 1'b0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_flags", {sat_flag, ovf_flag}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check("mid_no_stale", m_axis_data_tvalid, 1'b0);
    end
    step(1'b1, longint'(3) << 15, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("mid_resume", m_axis_data_tdata, 16'h0003);
    drain();

    // Random traffic against the model.
    for (int n = 0; n < 12000; n++) begin
      x = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) x = (x <<< 30) >>> 30;
      else                           x = (x <<< 33) >>> 33;
      v = ($urandom_range(0, 99) < 85);
      r = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 2);
      step(v, x, r, c, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
